// File: rtl/scoreboard_reg_file.sv
// scoreboard_reg_file
//   Register file with a per-register busy scoreboard. It sits between decode,
//   which reads operands and reserves destinations, and writeback, which writes
//   results.
//   - Registers 0 .. NUM_REGS-NUM_WIDE-1 are NARROW_W wide and read back
//     zero-extended. The top NUM_WIDE registers are WIDE_W wide.
//   - There are two combinational read ports. A same-cycle writeback is
//     forwarded to a matching read port, and that forward also clears the
//     port's busy flag.
//   - The busy bit of a register is set by a reserve and cleared by a write.
//     When both hit the same index in one cycle, the reserve wins, because it
//     comes from a newer producer.
//   - rsv_err is a one-cycle registered flag. It marks a reserve of a register
//     that is already busy and is not being written in that cycle.
//   - busy_cnt is the registered population count of the busy vector.
// Build option:
//   RF_ZERO_REG_EN - index 0 is hardwired to zero. Writes and reserves to it
//                    are dropped, and it is never forwarded or busy.
module scoreboard_reg_file #(
    parameter int NARROW_W = 16,
    parameter int WIDE_W   = 24,
    parameter int NUM_REGS = 32,
    parameter int NUM_WIDE = 4,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx_1,
    input  logic [IDX_W-1:0]  rd_idx_2,
    output logic [WIDE_W-1:0] rd_data_1,
    output logic [WIDE_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WIDE_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [IDX_W-1:0]  rsv_idx,
    output logic              rsv_err,
    output logic [CNT_W-1:0]  busy_cnt
);

    localparam int NUM_NARROW = NUM_REGS - NUM_WIDE;

    logic [NARROW_W-1:0] narrow_q [NUM_NARROW];
    logic [NARROW_W-1:0] narrow_d [NUM_NARROW];
    logic [WIDE_W-1:0]   wide_q   [NUM_WIDE];
    logic [WIDE_W-1:0]   wide_d   [NUM_WIDE];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                rsv_err_q;
    logic                rsv_err_d;
    logic [CNT_W-1:0]    busy_cnt_q;
    logic [CNT_W-1:0]    busy_cnt_d;

    logic                wr_ok;
    logic                rsv_ok;
    logic [WIDE_W-1:0]   wr_masked;

    // Qualify write and reserve requests. Index 0 is dropped when it is the
    // hardwired zero register.
    always_comb begin
        wr_ok  = wr_en;
        rsv_ok = rsv_en;
`ifdef RF_ZERO_REG_EN
        if (wr_idx == '0)
            wr_ok = 1'b0;
        if (rsv_idx == '0)
            rsv_ok = 1'b0;
`endif
        if (wr_idx >= IDX_W'(NUM_NARROW))
            wr_masked = wr_data;
        else
            wr_masked = WIDE_W'(wr_data[NARROW_W-1:0]);
    end

    // Registered contents of one index, zero-extended to WIDE_W.
    function automatic logic [WIDE_W-1:0] stored_value(input logic [IDX_W-1:0] idx);
        logic [WIDE_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_NARROW; i++)
            if (idx == IDX_W'(i))
                v = WIDE_W'(narrow_q[i]);
        for (int j = 0; j < NUM_WIDE; j++)
            if (idx == IDX_W'(NUM_NARROW + j))
                v = wide_q[j];
        return v;
    endfunction

    // Read value of one port, with the same-cycle writeback forwarded to it.
    function automatic logic [WIDE_W-1:0] read_value(input logic [IDX_W-1:0] idx);
        logic [WIDE_W-1:0] v;
        if (wr_ok && (wr_idx == idx))
            v = wr_masked;
        else
            v = stored_value(idx);
`ifdef RF_ZERO_REG_EN
        if (idx == '0)
            v = '0;
`endif
        return v;
    endfunction

    // Read ports. A forwarded write also removes the hazard in the same cycle.
    always_comb begin
        rd_data_1 = read_value(rd_idx_1);
        rd_data_2 = read_value(rd_idx_2);
        rd_busy_1 = busy_q[rd_idx_1] & ~(wr_ok && (wr_idx == rd_idx_1));
        rd_busy_2 = busy_q[rd_idx_2] & ~(wr_ok && (wr_idx == rd_idx_2));
    end

    // Next register contents from the writeback port. Narrow targets keep
    // only the low NARROW_W bits of the write data.
    always_comb begin
        for (int i = 0; i < NUM_NARROW; i++) begin
            narrow_d[i] = narrow_q[i];
            if (wr_ok && (wr_idx == IDX_W'(i)))
                narrow_d[i] = wr_data[NARROW_W-1:0];
        end
        for (int j = 0; j < NUM_WIDE; j++) begin
            wide_d[j] = wide_q[j];
            if (wr_ok && (wr_idx == IDX_W'(NUM_NARROW + j)))
                wide_d[j] = wr_data;
        end
    end

    // Next scoreboard state. The set is applied after the clear, so a reserve
    // wins over a write to the same index. busy_cnt is the popcount of the
    // next busy vector.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)
            busy_d[wr_idx] = 1'b0;
        if (rsv_ok)
            busy_d[rsv_idx] = 1'b1;

        rsv_err_d = rsv_ok && busy_q[rsv_idx] && !(wr_ok && (wr_idx == rsv_idx));

        busy_cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++)
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end

    // State registers. A synchronous reset clears everything and takes
    // priority over a write or reserve in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NARROW; i++)
                narrow_q[i] <= '0;
            for (int j = 0; j < NUM_WIDE; j++)
                wide_q[j] <= '0;
            busy_q     <= '0;
            rsv_err_q  <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_NARROW; i++)
                narrow_q[i] <= narrow_d[i];
            for (int j = 0; j < NUM_WIDE; j++)
                wide_q[j] <= wide_d[j];
            busy_q     <= busy_d;
            rsv_err_q  <= rsv_err_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rsv_err  = rsv_err_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file. Inputs change 1ns after each rising
// edge. Registered outputs are checked right after the edge, and
// combinational outputs are checked 1ns after the inputs change.
module tb_scoreboard_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_idx_1, rd_idx_2;
    logic [23:0] rd_data_1, rd_data_2;
    logic        rd_busy_1, rd_busy_2;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [23:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_idx;
    logic        rsv_err;
    logic [5:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;

    scoreboard_reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_1  (rd_idx_1),
        .rd_idx_2  (rd_idx_2),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2),
        .rd_busy_1 (rd_busy_1),
        .rd_busy_2 (rd_busy_2),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_idx   (rsv_idx),
        .rsv_err   (rsv_err),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_idx_1 = '0; rd_idx_2 = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_idx = '0;

        // Reset
        tick();
        check("rst_rd_data_1", rd_data_1, 0);
        check("rst_rd_busy_1", rd_busy_1, 0);
        check("rst_busy_cnt", busy_cnt, 0);
        check("rst_rsv_err", rsv_err, 0);
        rst = 1'b0;

        // Narrow write with same-cycle forwarding
        wr_en = 1'b1; wr_idx = 5'd5; wr_data = 24'hABCDEF; rd_idx_1 = 5'd5;
        #1;
        check("bypass_narrow", rd_data_1, 24'h00CDEF);
        tick();
        wr_en = 1'b0;
        #1;
        check("stored_narrow", rd_data_1, 24'h00CDEF);

        // Wide write, then both ports read at once
        wr_en = 1'b1; wr_idx = 5'd29; wr_data = 24'h123456; rd_idx_2 = 5'd29;
        #1;
        check("bypass_wide", rd_data_2, 24'h123456);
        tick();
        wr_en = 1'b0; rd_idx_1 = 5'd29; rd_idx_2 = 5'd5;
        #1;
        check("dual_rd_1", rd_data_1, 24'h123456);
        check("dual_rd_2", rd_data_2, 24'h00CDEF);

        // Narrow/wide boundary: index 27 is the last narrow register, 28 the first wide one
        wr_en = 1'b1; wr_idx = 5'd27; wr_data = 24'hA5A5A5;
        tick();
        wr_idx = 5'd28;
        tick();
        wr_en = 1'b0; rd_idx_1 = 5'd27; rd_idx_2 = 5'd28;
        #1;
        check("last_narrow", rd_data_1, 24'h00A5A5);
        check("first_wide", rd_data_2, 24'hA5A5A5);

        // Reserve, repeated reserve, then writeback
        rsv_en = 1'b1; rsv_idx = 5'd7; rd_idx_1 = 5'd7;
        tick();
        rsv_en = 1'b0;
        check("rsv1_err", rsv_err, 0);
        check("rsv1_cnt", busy_cnt, 1);
        #1;
        check("rsv1_busy", rd_busy_1, 1);
        rsv_en = 1'b1;
        tick();
        rsv_en = 1'b0;
        check("rsv2_err", rsv_err, 1);
        check("rsv2_cnt", busy_cnt, 1);
        check("rsv2_busy", rd_busy_1, 1);
        tick();
        check("rsv_err_pulse", rsv_err, 0);
        wr_en = 1'b1; wr_idx = 5'd7; wr_data = 24'h00BEEF;
        #1;
        check("wb_clears_busy", rd_busy_1, 0);
        check("wb_bypass", rd_data_1, 24'h00BEEF);
        tick();
        wr_en = 1'b0;
        check("wb_cnt", busy_cnt, 0);
        #1;
        check("wb_busy_after", rd_busy_1, 0);

        // Reserve and write to the same index in one cycle
        rsv_en = 1'b1; rsv_idx = 5'd3; wr_en = 1'b1; wr_idx = 5'd3; wr_data = 24'hFF1234;
        rd_idx_1 = 5'd3; rd_idx_2 = 5'd9;
        tick();
        check("same_idx_err", rsv_err, 0);
        check("same_idx_cnt", busy_cnt, 1);
        // Clear index 3 and reserve index 9 in the same cycle
        rsv_idx = 5'd9; wr_idx = 5'd3; wr_data = 24'h000055;
        tick();
        rsv_en = 1'b0; wr_en = 1'b0;
        check("swap_cnt", busy_cnt, 1);
        #1;
        check("swap_busy3", rd_busy_1, 0);
        check("swap_busy9", rd_busy_2, 1);
        check("swap_data3", rd_data_1, 24'h000055);
        // Reserve a busy register while it is being written: no error
        rsv_en = 1'b1; rsv_idx = 5'd9; wr_en = 1'b1; wr_idx = 5'd9; wr_data = 24'h000011;
        tick();
        rsv_en = 1'b0; wr_en = 1'b0;
        check("rsv_wr_busy_err", rsv_err, 0);
        check("rsv_wr_busy_cnt", busy_cnt, 1);
        // Write to a register that is not busy
        wr_en = 1'b1; wr_idx = 5'd4; wr_data = 24'h000777;
        tick();
        wr_en = 1'b0;
        check("wr_nonbusy_err", rsv_err, 0);
        check("wr_nonbusy_cnt", busy_cnt, 1);

        // Reset in mid-run overrides a write and a reserve in the same cycle
        rst = 1'b1; rsv_en = 1'b1; rsv_idx = 5'd12; wr_en = 1'b1; wr_idx = 5'd29; wr_data = 24'h777777;
        tick();
        rst = 1'b0; rsv_en = 1'b0; wr_en = 1'b0; rd_idx_1 = 5'd29; rd_idx_2 = 5'd9;
        check("rst2_cnt", busy_cnt, 0);
        check("rst2_err", rsv_err, 0);
        #1;
        check("rst2_data29", rd_data_1, 0);
        check("rst2_busy9", rd_busy_2, 0);
        rd_idx_1 = 5'd5; rd_idx_2 = 5'd12;
        #1;
        check("rst2_data5", rd_data_1, 0);
        check("rst2_busy12", rd_busy_2, 0);

        // Index 0
        wr_en = 1'b1; wr_idx = 5'd0; wr_data = 24'h00FFFF; rsv_en = 1'b1; rsv_idx = 5'd0; rd_idx_1 = 5'd0;
        #1;
`ifdef RF_ZERO_REG_EN
        check("zero_bypass", rd_data_1, 0);
`else
        check("zero_bypass", rd_data_1, 24'h00FFFF);
`endif
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
`ifdef RF_ZERO_REG_EN
        check("zero_data", rd_data_1, 0);
        check("zero_busy", rd_busy_1, 0);
        check("zero_cnt", busy_cnt, 0);
`else
        check("zero_data", rd_data_1, 24'h00FFFF);
        check("zero_busy", rd_busy_1, 1);
        check("zero_cnt", busy_cnt, 1);
`endif

        // Reserve every register: the count saturates at the register count
        rsv_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rsv_idx = 5'(i);
            tick();
        end
        rsv_en = 1'b0;
`ifdef RF_ZERO_REG_EN
        check("full_cnt", busy_cnt, 31);
`else
        check("full_cnt", busy_cnt, 32);
`endif
        tick();
        check("full_cnt_hold", busy_cnt, busy_cnt_expected_full());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [31:0] busy_cnt_expected_full();
`ifdef RF_ZERO_REG_EN
        return 32'd31;
`else
        return 32'd32;
`endif
    endfunction

endmodule
